// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the register-bank write arbiter: per-requester
// request/address/data in, registered grant and bank write strobe out.
interface reg_write_arbiter_if #(
    parameter int N  = 4,
    parameter int AW = 3,
    parameter int DW = 8
);
    logic [N-1:0]    inReq;
    logic [N*AW-1:0] inAddr;
    logic [N*DW-1:0] inData;
    logic [N-1:0]    outGnt;
    logic            outWrEn;
    logic [AW-1:0]   outWrAddr;
    logic [DW-1:0]   outWrData;
    logic            outBusy;

    modport master (
        output inReq, inAddr, inData,
        input  outGnt, outWrEn, outWrAddr, outWrData, outBusy
    );

    modport slave (
        input  inReq, inAddr, inData,
        output outGnt, outWrEn, outWrAddr, outWrData, outBusy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among N requesters,
// with a per-grant burst limit that only applies while others are waiting.
module reg_write_arbiter #(
    parameter int N         = 4,
    parameter int AW        = 3,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 inClk,
    input  logic                 inRst,
    reg_write_arbiter_if.slave   bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    logic [AW-1:0]   req_addr [N];
    logic [DW-1:0]   req_data [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign req_addr[gi] = bus.inAddr[gi*AW +: AW];
            assign req_data[gi] = bus.inData[gi*DW +: DW];
        end
    endgenerate

    // First requester at or after 'start', wrapping modulo N.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [PW-1:0] start);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            if (!found && req[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic            owner_req;
    logic [N-1:0]    others;
    logic            others_pending;
    logic            beat;
    logic [PW-1:0]   owner_succ;
    logic [PW-1:0]   succ_pick;

    always_comb begin
        owner_req      = bus.inReq[owner_q];
        others         = bus.inReq & ~gnt_q;
        others_pending = |others;
        beat           = (state_q == S_GRANT) && owner_req;
        owner_succ     = PW'((int'(owner_q) + 1) % N);
        succ_pick      = rr_pick(others, owner_succ);

        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (beat) begin
            wr_en_d   = 1'b1;
            wr_addr_d = req_addr[owner_q];
            wr_data_d = req_data[owner_q];
        end

        case (state_q)
            S_IDLE: begin
                if (|bus.inReq) begin
                    state_d = S_GRANT;
                    owner_d = rr_pick(bus.inReq, ptr_q);
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (!owner_req) begin
                    ptr_d = owner_succ;
                    cnt_d = '0;
                    if (others_pending) owner_d = succ_pick;
                    else                state_d = S_IDLE;
                end else if (cnt_q == CW'(MAX_BURST - 1)) begin
                    // Burst limit only forces a handover when someone is waiting.
                    cnt_d = '0;
                    if (others_pending) begin
                        owner_d = succ_pick;
                        ptr_d   = owner_succ;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        gnt_d = '0;
        if (state_d == S_GRANT) gnt_d[owner_d] = 1'b1;
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.outGnt    = gnt_q;
    assign bus.outWrEn   = wr_en_q;
    assign bus.outWrAddr = wr_addr_q;
    assign bus.outWrData = wr_data_q;
    assign bus.outBusy   = (state_q == S_GRANT);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: each step advances one clock edge and
// checks grant, write strobe, address, data and busy against hand-derived values.
module tb_reg_write_arbiter;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    reg_write_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .inClk (clk),
        .inRst (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Busy must track a non-zero grant, so its expectation derives from g.
    task automatic expect_cyc(input string tag, input int g, input int en, input int a, input int d);
        $display("[TB] %s gnt=%b wr=%0d addr=%0d data=%02h busy=%0d",
                 tag, bus.outGnt, bus.outWrEn, bus.outWrAddr, bus.outWrData, bus.outBusy);
        check_eq({tag, ".gnt"},  32'(bus.outGnt),    32'(g));
        check_eq({tag, ".wren"}, 32'(bus.outWrEn),   32'(en));
        check_eq({tag, ".addr"}, 32'(bus.outWrAddr), 32'(a));
        check_eq({tag, ".data"}, 32'(bus.outWrData), 32'(d));
        check_eq({tag, ".busy"}, 32'(bus.outBusy),   32'(g != 0));
    endtask

    initial begin
        int g, en, a, d;
        // r0: 1/11, r1: 2/22, r2: 5/A5, r3: 7/33
        bus.inAddr = {3'd7, 3'd5, 3'd2, 3'd1};
        bus.inData = {8'h33, 8'hA5, 8'h22, 8'h11};
        bus.inReq  = 4'b1111;
        rst        = 1'b1;

        // Reset held with all requests high
        step(); expect_cyc("rst0", 0, 0, 0, 0);
        step(); expect_cyc("rst1", 0, 0, 0, 0);
        rst = 1'b0;
        step(); expect_cyc("rel_gnt", 1, 0, 0, 0);
        step(); expect_cyc("rel_wr", 1, 1, 1, 8'h11);
        bus.inReq = 4'b0000;
        step(); expect_cyc("rel_idle", 0, 0, 1, 8'h11);   // ptr -> 1

        // Single requester 2 held for six beats across the burst rollover
        bus.inReq = 4'b0100;
        for (int c = 1; c <= 7; c++) begin
            step();
            en = (c >= 2) ? 1 : 0;
            a  = (c >= 2) ? 5 : 1;
            d  = (c >= 2) ? 8'hA5 : 8'h11;
            expect_cyc($sformatf("solo_c%0d", c), 4'b0100, en, a, d);
        end
        bus.inReq = 4'b0000;
        step(); expect_cyc("solo_idle", 0, 0, 5, 8'hA5);  // ptr -> 3

        // Requesters 0 and 1 alternate in bursts of four with no strobe gap
        bus.inReq = 4'b0011;
        for (int c = 1; c <= 9; c++) begin
            step();
            g  = (c <= 4) ? 1 : (c <= 8) ? 2 : 1;
            en = (c >= 2) ? 1 : 0;
            a  = (c < 2) ? 5 : (c <= 5) ? 1 : 2;
            d  = (c < 2) ? 8'hA5 : (c <= 5) ? 8'h11 : 8'h22;
            expect_cyc($sformatf("rr_c%0d", c), g, en, a, d);
        end
        bus.inReq = 4'b0000;
        step(); expect_cyc("rr_idle", 0, 0, 2, 8'h22);    // ptr -> 1

        // Park ptr at 2: grant 1, then drop before any beat
        bus.inReq = 4'b0010;
        step(); expect_cyc("park_gnt", 2, 0, 2, 8'h22);
        bus.inReq = 4'b0000;
        step(); expect_cyc("park_idle", 0, 0, 2, 8'h22);  // ptr -> 2

        // ptr=2 with 0 and 3 rising together: 3 first, then 0 without idle
        bus.inReq = 4'b1001;
        step(); expect_cyc("sim_gnt3", 8, 0, 2, 8'h22);
        step(); expect_cyc("sim_wr3", 8, 1, 7, 8'h33);
        bus.inReq = 4'b0001;
        step(); expect_cyc("sim_gnt0", 1, 0, 7, 8'h33);
        step(); expect_cyc("sim_wr0", 1, 1, 1, 8'h11);
        bus.inReq = 4'b0000;
        step(); expect_cyc("sim_idle", 0, 0, 1, 8'h11);   // ptr -> 1

        // Owner 1 drops after two beats while 3 waits
        bus.inReq = 4'b0010;
        step(); expect_cyc("drop_gnt1", 2, 0, 1, 8'h11);
        bus.inReq = 4'b1010;
        step(); expect_cyc("drop_b1", 2, 1, 2, 8'h22);
        step(); expect_cyc("drop_b2", 2, 1, 2, 8'h22);
        bus.inReq = 4'b1000;
        step(); expect_cyc("drop_move", 8, 0, 2, 8'h22);
        step(); expect_cyc("drop_wr3", 8, 1, 7, 8'h33);
        bus.inReq = 4'b0000;
        step(); expect_cyc("drop_idle", 0, 0, 7, 8'h33);  // ptr -> 0

        // Reset pulsed during the owner's third beat
        bus.inReq = 4'b0100;
        step(); expect_cyc("mrst_gnt", 4, 0, 7, 8'h33);
        step(); expect_cyc("mrst_b1", 4, 1, 5, 8'hA5);
        step(); expect_cyc("mrst_b2", 4, 1, 5, 8'hA5);
        rst = 1'b1;
        step(); expect_cyc("mrst_hit", 0, 0, 0, 0);
        rst = 1'b0;
        bus.inReq = 4'b0101;
        step(); expect_cyc("mrst_regnt", 1, 0, 0, 0);
        step(); expect_cyc("mrst_wr0", 1, 1, 1, 8'h11);
        bus.inReq = 4'b0000;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

- Round-robin arbiter sharing one write port of a DFF-based register bank among `N` requesters.
- Each requester holds a request with address and data.
- The arbiter grants one requester at a time and forwards accepted beats as registered write strobes to the bank.
- A burst limit keeps any one requester from holding the port while others wait.

## Interface
- `N`, 4: number of requesters (2..8).
- `AW`, 3: register bank address width.
- `DW`, 8: data width.
- `MAX_BURST`, 4: maximum consecutive accepted beats per grant while another requester is pending (≥1).
- `inClk`  input  1: single clock; all state updates on the rising edge.
- `inRst`  input  1: reset, synchronous, active-high.
- `inReq`  input  N: per-requester request level.
- `inAddr`  input  N*AW: flattened addresses; requester i at bits [i*AW +: AW].
- `inData`  input  N*DW: flattened data; requester i at bits [i*DW +: DW].
- `outGnt`  output  N: registered one-hot grant (all-zero when idle).
- `outWrEn`  output  1: registered write strobe to the bank.
- `outWrAddr`  output  AW: registered write address.
- `outWrData`  output  DW: registered write data.
- `outBusy`  output  1: high while in GRANT state.

## Operation
- State machine:
  - IDLE: `outGnt`=0.
  - GRANT: exactly one `outGnt` bit high. That bit's requester is the owner.
- Beat acceptance: a beat is accepted in any cycle where `outGnt[i] & inReq[i]`.
  - The accepted beat's addr/data are registered into `outWrAddr`/`outWrData` with `outWrEn`=1 on the next cycle.
  - Otherwise `outWrEn`=0 and the address/data outputs hold their last values.
- Winner selection: the first index with `inReq` high, scanning from `ptr` upward modulo N. `ptr` resets to 0.
- Transitions:
  - IDLE → GRANT when any `inReq` is high. The winner becomes owner, and `cnt` is cleared.
  - GRANT, owner `inReq` low:
    - If another requester is pending, the grant moves directly to the next winner scanning from owner+1 (no idle cycle).
    - Otherwise go to IDLE.
    - In both cases `ptr`←owner+1.
  - GRANT, owner accepted beat, `cnt`+1 = `MAX_BURST`:
    - If another requester is pending, the grant moves to the next winner scanning from owner+1, `ptr`←owner+1, and `cnt`←0.
    - Otherwise the owner keeps the grant and `cnt`←0.
  - GRANT, owner accepted beat below the limit: `cnt`+1, grant held.
- `cnt` width is clog2(`MAX_BURST`+1). It never exceeds `MAX_BURST`-1 at a clock edge.
- Requests from non-owners never produce a write.
- `inAddr`/`inData` of non-granted requesters are ignored.

## Timing
- Reset values: `outGnt`=0, `outWrEn`=0, `outWrAddr`=0, `outWrData`=0, `outBusy`=0. Internal state: IDLE, `ptr`=0, `cnt`=0.
- Latency from an idle arbiter:
  - Request high at edge k → `outGnt` high after edge k+1.
  - First `outWrEn` after edge k+2.
- Throughput: one write per cycle while the owner holds its request. A grant handover inserts no bubble.
- Grant deassertion: the owner dropping `inReq` at edge k clears or moves `outGnt` after edge k+1. The cycle in which `outGnt` is high but `inReq` is low writes nothing.
- Simultaneous requests: resolved purely by `ptr` order. No priority beyond round-robin.
- Reset mid-burst: `inRst` high at any edge forces the reset values at that edge.
  - An accepted beat in the same cycle is dropped.
  - `inRst` has priority over every transition.
- `outBusy` is registered and equals (state==GRANT). It is coincident with `outGnt`≠0.

## Test plan
- Reset with `inReq`=4'b1111 held: all outputs 0 while `inRst`=1. After release, `outGnt`=0001 one cycle later and `outWrEn`=1 one cycle after that.
- Single requester 2, addr=5, data=0xA5, held 6 cycles with no others: `outGnt`=0100 continuously; six strobes with addr 5, data 0xA5; `MAX_BURST` rollover does not drop the grant.
- Requesters 0 and 1 held continuously: grant alternates 0001 ×4 cycles, then 0010 ×4 cycles, with exactly 4 writes per owner and no gap in `outWrEn`.
- `ptr`=2, requests 0 and 3 rise in the same cycle: 1000 granted first; after requester 3 drops, 0001 follows with no idle cycle.
- Owner 1 drops `inReq` after 2 beats while 3 is pending: exactly 2 writes from 1, then `outGnt`=1000 on the next cycle. The transition cycle has `outWrEn`=0.
- `inRst` pulsed during the owner's third beat: that beat is not written, all outputs return to 0, and arbitration restarts from requester 0.
